// File: rtl/tpg_pkg.sv
// Shared encodings for the video test-pattern generator: pattern modes and
// the on/off channel masks of the colour-bar rows.
package tpg_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_SMPTE = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_RAMP  = 2'd3
    } tpg_mode_e;

    localparam int unsigned NUM_BARS  = 7;
    localparam int unsigned BAR_IDX_W = 3;

    // Mask bits are {b,g,r}; bottom row is the reverse castellation strip.
    function automatic logic [2:0] bar_mask(input logic [BAR_IDX_W-1:0] idx,
                                            input logic bottom);
        logic [2:0] m;
        m = '0;
        case (idx)
            3'd0:    m = bottom ? 3'b100 : 3'b111;
            3'd1:    m = bottom ? 3'b000 : 3'b011;
            3'd2:    m = bottom ? 3'b101 : 3'b110;
            3'd3:    m = bottom ? 3'b000 : 3'b010;
            3'd4:    m = bottom ? 3'b110 : 3'b101;
            3'd5:    m = bottom ? 3'b000 : 3'b001;
            default: m = bottom ? 3'b111 : 3'b100;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tpg_raster_timing.sv
// Raster timing: pixel clock-enable divider, h/v counters and region decode,
// all advancing on the pixel enable of a single fast clock.
module tpg_raster_timing #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_DISPLAY = 256,
    parameter int unsigned H_FRONT   = 40,
    parameter int unsigned H_SYNC    = 25,
    parameter int unsigned H_BACK    = 60,
    parameter int unsigned V_DISPLAY = 240,
    parameter int unsigned V_FRONT   = 5,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BACK    = 14,
    parameter int unsigned H_W       = 9,
    parameter int unsigned V_W       = 9
) (
    input  logic           clk,
    input  logic           reset_n,
    output logic           pe,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic           visible,
    output logic           hsync_act,
    output logic           vsync_act,
    output logic           origin
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [V_W-1:0]   v_q, v_d;

    always_comb begin
        pe    = (div_q == DIV_W'(CLK_DIV - 1));
        div_d = pe ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (pe) begin
            if (32'(h_q) == H_TOTAL - 1) begin
                h_d = '0;
                v_d = (32'(v_q) == V_TOTAL - 1) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    always_comb begin
        h         = h_q;
        v         = v_q;
        visible   = (32'(h_q) < H_DISPLAY) && (32'(v_q) < V_DISPLAY);
        hsync_act = (32'(h_q) >= H_DISPLAY + H_FRONT) &&
                    (32'(h_q) <  H_DISPLAY + H_FRONT + H_SYNC);
        vsync_act = (32'(v_q) >= V_DISPLAY + V_FRONT) &&
                    (32'(v_q) <  V_DISPLAY + V_FRONT + V_SYNC);
        origin    = (h_q == '0) && (v_q == '0);
    end

endmodule

// File: rtl/test_pattern_generator.sv
// Video test-pattern source: bars, SMPTE split, checkerboard and gray ramp
// with one registered output stage, frame-start pulse and heartbeat LED.
module test_pattern_generator
    import tpg_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned H_DISPLAY    = 256,
    parameter int unsigned H_FRONT      = 40,
    parameter int unsigned H_SYNC       = 25,
    parameter int unsigned H_BACK       = 60,
    parameter int unsigned V_DISPLAY    = 240,
    parameter int unsigned V_FRONT      = 5,
    parameter int unsigned V_SYNC       = 3,
    parameter int unsigned V_BACK       = 14,
    parameter int unsigned H_SYNC_POL   = 1,
    parameter int unsigned V_SYNC_POL   = 1,
    parameter int unsigned COLOR_BITS   = 1,
    parameter int unsigned BAR_LEVEL    = 2**COLOR_BITS - 1,
    parameter int unsigned CHECK_LOG2   = 4,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              mode,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    display_on,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic                    frame_start,
    output logic                    frame_led
);

    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_W       = $clog2(H_TOTAL);
    localparam int unsigned V_W       = $clog2(V_TOTAL);
    localparam int unsigned BAR_W     = H_DISPLAY / NUM_BARS;
    localparam int unsigned BAR_CW    = $clog2(BAR_W + 1);
    localparam int unsigned RAMP_W    = H_DISPLAY >> COLOR_BITS;
    localparam int unsigned RAMP_CW   = $clog2(RAMP_W + 1);
    localparam int unsigned SPLIT_V   = (V_DISPLAY * 2) / 3;
    localparam int unsigned FC_W      = $clog2(BLINK_FRAMES + 1);
    localparam logic        H_IDLE    = (H_SYNC_POL != 0);
    localparam logic        V_IDLE    = (V_SYNC_POL != 0);
    localparam logic [COLOR_BITS-1:0] ON_LVL = COLOR_BITS'(BAR_LEVEL);

    logic           pe, visible, hsync_act, vsync_act, origin, line_end;
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;

    tpg_raster_timing #(
        .CLK_DIV   (CLK_DIV),
        .H_DISPLAY (H_DISPLAY),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_DISPLAY (V_DISPLAY),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .H_W       (H_W),
        .V_W       (V_W)
    ) u_timing (
        .clk       (clk),
        .reset_n   (reset_n),
        .pe        (pe),
        .h         (h),
        .v         (v),
        .visible   (visible),
        .hsync_act (hsync_act),
        .vsync_act (vsync_act),
        .origin    (origin)
    );

    tpg_mode_e              mode_q, mode_d, mode_sel;
    logic [BAR_CW-1:0]      bar_px_q, bar_px_d;
    logic [BAR_IDX_W-1:0]   bar_idx_q, bar_idx_d;
    logic [RAMP_CW-1:0]     ramp_px_q, ramp_px_d;
    logic [COLOR_BITS-1:0]  lvl_q, lvl_d;
    logic                   hsync_q, hsync_d, vsync_q, vsync_d;
    logic                   display_on_q, display_on_d;
    logic [3*COLOR_BITS-1:0] rgb_q, rgb_d, pix;
    logic                   armed_q, armed_d;
    logic                   frame_start_q, frame_start_d;
    logic [FC_W-1:0]        fcnt_q, fcnt_d;
    logic                   frame_led_q, frame_led_d;
    logic [2:0]             mask;

    assign line_end = (32'(h) == H_TOTAL - 1);

    // Bar and ramp position counters track the current h; cleared at line wrap.
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        ramp_px_d = ramp_px_q;
        lvl_d     = lvl_q;
        if (pe) begin
            if (line_end) begin
                bar_px_d  = '0;
                bar_idx_d = '0;
                ramp_px_d = '0;
                lvl_d     = '0;
            end else begin
                if (32'(bar_px_q) == BAR_W - 1) begin
                    bar_px_d = '0;
                    if (32'(bar_idx_q) != NUM_BARS - 1)
                        bar_idx_d = bar_idx_q + 1'b1;
                end else begin
                    bar_px_d = bar_px_q + 1'b1;
                end
                if (32'(ramp_px_q) == RAMP_W - 1) begin
                    ramp_px_d = '0;
                    if (lvl_q != '1)
                        lvl_d = lvl_q + 1'b1;
                end else begin
                    ramp_px_d = ramp_px_q + 1'b1;
                end
            end
        end
    end

    // At the frame origin the live mode input is used so pixel (0,0) already
    // shows the newly sampled pattern.
    always_comb begin
        mode_sel = origin ? tpg_mode_e'(mode) : mode_q;
        mode_d   = (pe && origin) ? tpg_mode_e'(mode) : mode_q;
        mask     = bar_mask(bar_idx_q, (mode_sel == MODE_SMPTE) && (32'(v) >= SPLIT_V));
        pix      = '0;
        case (mode_sel)
            MODE_BARS, MODE_SMPTE:
                pix = {mask[2] ? ON_LVL : '0, mask[1] ? ON_LVL : '0, mask[0] ? ON_LVL : '0};
            MODE_CHECK:
                pix = (h[CHECK_LOG2] ^ v[CHECK_LOG2]) ? '0 : '1;
            MODE_RAMP:
                pix = {3{lvl_q}};
            default:
                pix = '0;
        endcase
    end

    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        display_on_d  = display_on_q;
        rgb_d         = rgb_q;
        if (pe) begin
            hsync_d      = hsync_act ^ H_IDLE;
            vsync_d      = vsync_act ^ V_IDLE;
            display_on_d = visible;
            rgb_d        = visible ? pix : '0;
        end
        armed_d       = armed_q | pe;
        frame_start_d = pe && origin && armed_q;
        fcnt_d        = fcnt_q;
        frame_led_d   = frame_led_q;
        if (frame_start_q) begin
            if (32'(fcnt_q) == BLINK_FRAMES - 1) begin
                fcnt_d      = '0;
                frame_led_d = ~frame_led_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q        <= MODE_BARS;
            bar_px_q      <= '0;
            bar_idx_q     <= '0;
            ramp_px_q     <= '0;
            lvl_q         <= '0;
            hsync_q       <= H_IDLE;
            vsync_q       <= V_IDLE;
            display_on_q  <= 1'b0;
            rgb_q         <= '0;
            armed_q       <= 1'b0;
            frame_start_q <= 1'b0;
            fcnt_q        <= '0;
            frame_led_q   <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            bar_px_q      <= bar_px_d;
            bar_idx_q     <= bar_idx_d;
            ramp_px_q     <= ramp_px_d;
            lvl_q         <= lvl_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            rgb_q         <= rgb_d;
            armed_q       <= armed_d;
            frame_start_q <= frame_start_d;
            fcnt_q        <= fcnt_d;
            frame_led_q   <= frame_led_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
    assign frame_led   = frame_led_q;

endmodule

// File: tb/tb_test_pattern_generator.sv
// Scoreboard bench for test_pattern_generator on a reduced raster.
module tb_test_pattern_generator;

    localparam int CLK_DIV = 2;
    localparam int HD = 60, HF = 4, HS = 3, HB = 5;
    localparam int VD = 12, VF = 2, VS = 2, VB = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int CB = 2, BAR_LEVEL = 2, CL = 2, BLINK = 3;
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [5:0] rgb;
    } px_t;

    logic       clk, reset_n;
    logic [1:0] mode;
    logic       hsync, vsync, display_on, frame_start, frame_led;
    logic [5:0] rgb;

    test_pattern_generator #(
        .CLK_DIV      (CLK_DIV),
        .H_DISPLAY    (HD),
        .H_FRONT      (HF),
        .H_SYNC       (HS),
        .H_BACK       (HB),
        .V_DISPLAY    (VD),
        .V_FRONT      (VF),
        .V_SYNC       (VS),
        .V_BACK       (VB),
        .H_SYNC_POL   (1),
        .V_SYNC_POL   (1),
        .COLOR_BITS   (CB),
        .BAR_LEVEL    (BAR_LEVEL),
        .CHECK_LOG2   (CL),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode        (mode),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .rgb         (rgb),
        .frame_start (frame_start),
        .frame_led   (frame_led)
    );

    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic px_t model_px(int h, int v, logic [1:0] md);
        px_t        p;
        int         bar, lvl;
        logic       r_on, g_on, b_on;
        logic [1:0] lv;
        p.hs = !((h >= HD + HF) && (h < HD + HF + HS));
        p.vs = !((v >= VD + VF) && (v < VD + VF + VS));
        p.de = (h < HD) && (v < VD);
        bar  = h / (HD / 7);
        if (bar > 6) bar = 6;
        r_on = (bar == 0) || (bar == 1) || (bar == 4) || (bar == 5);
        g_on = (bar <= 3);
        b_on = (bar % 2 == 0);
        if (md == 2'd1 && v >= (VD * 2) / 3) begin
            case (bar)
                0:       {b_on, g_on, r_on} = 3'b100;
                2:       {b_on, g_on, r_on} = 3'b101;
                4:       {b_on, g_on, r_on} = 3'b110;
                6:       {b_on, g_on, r_on} = 3'b111;
                default: {b_on, g_on, r_on} = 3'b000;
            endcase
        end
        lv    = 2'(BAR_LEVEL);
        p.rgb = {b_on ? lv : 2'b00, g_on ? lv : 2'b00, r_on ? lv : 2'b00};
        if (md == 2'd2)
            p.rgb = ((((h >> CL) ^ (v >> CL)) & 1) != 0) ? 6'h00 : 6'h3f;
        if (md == 2'd3) begin
            lvl = h / (HD >> CB);
            if (lvl > 3) lvl = 3;
            lv    = 2'(lvl);
            p.rgb = {lv, lv, lv};
        end
        if (!p.de) p.rgb = 6'h00;
        return p;
    endfunction

    px_t  reset_px, cur_exp;
    px_t  exp_q[$];
    int   m_div, m_h, m_v, m_fcnt;
    logic [1:0] m_mode;
    logic m_armed, m_led, fs_exp, m_pe, led_prev;
    int   led_tog;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference raster model: pushes the expected registered pixel on each
    // pixel enable and compares against the DUT just after every edge.
    initial begin
        reset_px = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 6'h00};
        cur_exp  = reset_px;
        m_div = 0; m_h = 0; m_v = 0; m_fcnt = 0; m_mode = 2'd0;
        m_armed = 1'b0; m_led = 1'b0; fs_exp = 1'b0; led_prev = 1'b0; led_tog = 0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_div = 0; m_h = 0; m_v = 0; m_fcnt = 0; m_mode = 2'd0;
                m_armed = 1'b0; m_led = 1'b0; fs_exp = 1'b0;
                exp_q.push_back(reset_px);
            end else begin
                m_pe  = (m_div == CLK_DIV - 1);
                m_div = m_pe ? 0 : m_div + 1;
                if (fs_exp) begin
                    if (m_fcnt == BLINK - 1) begin
                        m_fcnt = 0;
                        m_led  = !m_led;
                    end else begin
                        m_fcnt++;
                    end
                end
                fs_exp = 1'b0;
                if (m_pe) begin
                    if (m_h == 0 && m_v == 0) begin
                        m_mode = mode;
                        fs_exp = m_armed;
                    end
                    m_armed = 1'b1;
                    exp_q.push_back(model_px(m_h, m_v, m_mode));
                    m_h++;
                    if (m_h == HT) begin
                        m_h = 0;
                        m_v++;
                        if (m_v == VT) m_v = 0;
                    end
                end
            end
            #1;
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            check_eq("pixel", {hsync, vsync, display_on, rgb}, cur_exp);
            check_eq("frame_start", frame_start, fs_exp);
            check_eq("frame_led", frame_led, m_led);
            if (frame_led !== led_prev) led_tog++;
            led_prev = frame_led;
        end
    end

    int n;

    initial begin
        reset_n = 1'b1;
        mode    = 2'd0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("reset_out", {hsync, vsync, display_on, rgb, frame_start, frame_led},
                 {reset_px, 1'b0, 1'b0});
        repeat (4) @(negedge clk);
        reset_n = 1'b1;

        n = 0;
        while (display_on !== 1'b1 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("first_pe_edge", n, CLK_DIV);

        repeat (1000 - n) @(negedge clk);
        mode = 2'd1;
        repeat (FRAME_CLKS) @(negedge clk);
        mode = 2'd2;
        repeat (FRAME_CLKS) @(negedge clk);
        mode = 2'd3;
        repeat (FRAME_CLKS) @(negedge clk);
        mode = 2'd0;
        repeat (2374) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_eq("async_reset_out", {hsync, vsync, display_on, rgb, frame_start, frame_led},
                 {reset_px, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        mode    = 2'd1;
        reset_n = 1'b1;
        led_tog = 0;

        n = 0;
        while (frame_start !== 1'b1 && n < 3 * FRAME_CLKS) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("first_frame_start_after_reset", n, CLK_DIV * (HT * VT + 1));

        repeat (FRAME_CLKS + 700) @(negedge clk);
        mode = 2'd3;
        repeat (5 * FRAME_CLKS - 700 + 50) @(negedge clk);
        check_eq("led_toggles", led_tog, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/test_pattern_generator.md
Name: test_pattern_generator

Overview:
Parametrised video test-pattern source. It generates its own raster timing from a single fast clock using a pixel clock-enable, not a derived clock. It produces four selectable patterns (colour bars, SMPTE split, checkerboard, gray ramp) at configurable colour depth, plus a frame-rate heartbeat LED. It drives the board's sync/RGB pins directly and replaces the fixed 1-bit bar generator.

Parameters:
CLK_DIV, 2, system clocks per pixel; pixel enable asserted 1 of every CLK_DIV cycles; CLK_DIV>=1
H_DISPLAY, 256, visible pixels per line; must be >=7*8
H_FRONT, 40, horizontal front porch (pixels)
H_SYNC, 25, horizontal sync width (pixels)
H_BACK, 60, horizontal back porch (pixels)
V_DISPLAY, 240, visible lines
V_FRONT, 5, vertical front porch (lines)
V_SYNC, 3, vertical sync width (lines)
V_BACK, 14, vertical back porch (lines)
H_SYNC_POL, 1, 1 = hsync active-low
V_SYNC_POL, 1, 1 = vsync active-low
COLOR_BITS, 1, bits per channel
BAR_LEVEL, 2**COLOR_BITS-1, channel code for an "on" bar channel (75 % level set here)
CHECK_LOG2, 4, checker square size = 2**CHECK_LOG2 pixels/lines
BLINK_FRAMES, 30, frames between frame_led toggles

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mode  in  2  pattern select: 0 bars, 1 SMPTE split, 2 checker, 3 ramp
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
display_on  out  1  visible-region flag, aligned with rgb
rgb  out  3*COLOR_BITS  {b,g,r}, each COLOR_BITS wide
frame_start  out  1  one-clk pulse on the clock after pixel (0,0) is registered
frame_led  out  1  heartbeat, toggles every BLINK_FRAMES frames

Behaviour:
- Reset (async assert, sync release): divider, h, v, bar, ramp and frame counters = 0. mode_q = 0. rgb = 0, display_on = 0, hsync/vsync at inactive level, frame_start = 0, frame_led = 0.
- Pixel enable pe: divider counts 0..CLK_DIV-1; pe = 1 when divider = CLK_DIV-1. All raster state advances only on pe.
- H_TOTAL = sum of H_*. h wraps H_TOTAL-1 -> 0; v increments on h wrap and wraps at V_TOTAL-1 -> 0.
- Regions: h<H_DISPLAY and v<V_DISPLAY = visible. hsync active for H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC. vsync uses the same rule on v.
- mode is sampled into mode_q only on pe at h=0, v=0. A mid-frame change takes effect the next frame.
- Bar index: 0 at h=0; steps after every BAR_W = H_DISPLAY/7 pixels; saturates at 6, so remainder pixels take bar 6.
- Bar colours 0..6 are white, yellow, cyan, green, magenta, red, blue:
  - r on for bars {0,1,4,5}
  - g on for bars 0..3
  - b on for even bars
  - An "on" channel outputs BAR_LEVEL; an "off" channel outputs 0.
- Mode 1, top region v < (V_DISPLAY*2)/3 (constant): the mode-0 bars.
- Mode 1, bottom region: reverse castellation per bar index, blue, black, magenta, black, cyan, black, white.
- Mode 2: white (all channels full scale) when h[CHECK_LOG2] XOR v[CHECK_LOG2] = 0, else black.
- Mode 3: gray level counter 0 at h=0; increments every H_DISPLAY>>COLOR_BITS pixels; saturates at 2**COLOR_BITS-1; all three channels equal the counter.
- Output pipeline, updated on pe:
  - hsync, vsync, display_on and rgb are registered together in one stage, so latency is 1 pixel from counter state and all four stay mutually aligned.
  - rgb is forced to 0 when not visible.
- frame_start: 1-clk pulse on the clk following the pe that registers pixel (0,0).
- Frame counter: increments on frame_start. On reaching BLINK_FRAMES-1 it clears and toggles frame_led, giving exactly BLINK_FRAMES frames per toggle.
- Reset mid-frame: all outputs return to reset values immediately; the raster restarts at (0,0) after release.

Decomposition:
- Package tpg_pkg holds:
  - mode encodings (MODE_BARS, MODE_SMPTE, MODE_CHECK, MODE_RAMP)
  - NUM_BARS = 7
  - bar colour table, 3-bit on/off masks for the top and bottom rows
- One sub-module, tpg_raster_timing: divider, h/v counters, sync/visible decode, pe and frame-origin flags. The pattern logic and output registers stay in the top module.

Test Plan:
- Reset held, then released with defaults -> all outputs at reset values; first pe at clk 2; hsync low for exactly 25*2 clks starting at h=296; line period 381*2 clks; frame 262 lines.
- Mode 0, COLOR_BITS=1 -> pixel 35 rgb=3'b111; pixel 36 rgb=3'b011 (yellow); pixels 216..255 rgb=3'b100 (blue); pixel 256 rgb=0 with display_on=0.
- COLOR_BITS=2, BAR_LEVEL=2, mode 0 -> white = {2,2,2} (6'b101010); mode 2 -> white squares = {3,3,3}, square edge at h=16.
- mode 0 -> 3 at v=100 -> current frame remains bars; next frame pixel 0 rgb=0 and last visible pixel 255 rgb={3,3,3} (COLOR_BITS=2).
- 61 frames at BLINK_FRAMES=30 -> frame_led toggles after the 30th and 60th frame_start; frame_start pulses are exactly 1 clk wide.
- reset_n dropped at h=100, v=50 -> outputs return to reset values without a clock edge; after release, the first frame_start occurs one full frame later.
